// File: rtl/cdc_hsk_pkg.sv
// Shared types and helpers for the destination-side handshake responder.
package cdc_hsk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } hsk_state_t;

  // Bits needed to hold an occupancy count of 0..depth inclusive.
  function automatic int unsigned fill_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/cdc_hsk_fifo.sv
// Synchronous first-word-fall-through FIFO; occupancy kept in a separate counter
// so pointers can wrap modulo DEPTH without a full/empty ambiguity bit.
module cdc_hsk_fifo
  import cdc_hsk_pkg::*;
#(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned FILL_W = fill_width(DEPTH),
  localparam int unsigned PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_data,
  input  logic              pop,
  output logic [WIDTH-1:0]  pop_data,
  output logic [FILL_W-1:0] fill
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  // Storage array carries no reset; validity comes from fill.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fill <= fill + FILL_W'(1);
        2'b01:   fill <= fill - FILL_W'(1);
        default: fill <= fill;
      endcase
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/cdc_hsk_dest_ctrl.sv
// Destination-side responder for an external-ack CDC handshake: captures one word
// per request into a FWFT FIFO and withholds dest_ack while the FIFO cannot take it.
module cdc_hsk_dest_ctrl
  import cdc_hsk_pkg::*;
#(
  parameter  int unsigned WIDTH  = 16,
  parameter  int unsigned DEPTH  = 4,
  localparam int unsigned FILL_W = fill_width(DEPTH)
) (
  input  logic              dest_clk,
  input  logic              dest_rst_n,
  input  logic              dest_req,
  input  logic [WIDTH-1:0]  dest_in,
  output logic              dest_ack,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [FILL_W-1:0] fill,
  output logic              req_stall
);

  hsk_state_t state_q;
  hsk_state_t state_d;
  logic       push;
  logic       pop;
  logic       push_ok;
  logic       ack_q;

  assign m_valid = (fill != '0);
  assign pop     = m_valid & m_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok = (fill < FILL_W'(DEPTH)) | pop;

  always_ff @(posedge dest_clk) begin
    if (!dest_rst_n) begin
      state_q <= IDLE;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= (state_d == ACK);
    end
  end

  // Next state, push strobe and stall indication.
  always_comb begin
    state_d   = state_q;
    push      = 1'b0;
    req_stall = 1'b0;
    case (state_q)
      IDLE: begin
        if (dest_req) begin
          if (push_ok) begin
            push    = 1'b1;
            state_d = ACK;
          end else begin
            req_stall = 1'b1;
          end
        end
      end
      ACK: begin
        if (!dest_req) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dest_ack = ack_q;

  cdc_hsk_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (dest_clk),
    .rst_n     (dest_rst_n),
    .push      (push),
    .push_data (dest_in),
    .pop       (pop),
    .pop_data  (m_data),
    .fill      (fill)
  );

endmodule

// File: tb/tb_cdc_hsk_dest_ctrl.sv
// Bench for cdc_hsk_dest_ctrl: directed scenarios plus a randomized handshake
// source, all compared every cycle against a queue-based reference model.
module tb_cdc_hsk_dest_ctrl;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned FW    = $clog2(DEPTH + 1);
  localparam int          NWORDS = 64;
  localparam int          SYNC   = 4;

  logic             clk = 1'b0;
  logic             dest_rst_n;
  logic             dest_req;
  logic [WIDTH-1:0] dest_in;
  logic             dest_ack;
  logic [WIDTH-1:0] m_data;
  logic             m_valid;
  logic             m_ready;
  logic [FW-1:0]    fill;
  logic             req_stall;

  always #5 clk = ~clk;

  cdc_hsk_dest_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .dest_clk   (clk),
    .dest_rst_n (dest_rst_n),
    .dest_req   (dest_req),
    .dest_in    (dest_in),
    .dest_ack   (dest_ack),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .fill       (fill),
    .req_stall  (req_stall)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: ack level plus a queue of stored words.
  bit               m_ack;
  logic [WIDTH-1:0] mq[$];
  logic [WIDTH-1:0] sent[$];
  logic [WIDTH-1:0] rx[$];
  logic [WIDTH-1:0] obs_head;
  logic             last_req = 1'b0;
  logic             last_rst = 1'b0;
  logic             prev_ack = 1'b0;

  function automatic void model_edge();
    bit pop, can, cap;
    last_req = dest_req;
    last_rst = dest_rst_n;
    if (!dest_rst_n) begin
      m_ack = 1'b0;
      mq.delete();
      return;
    end
    pop = (mq.size() > 0) && (m_ready == 1'b1);
    can = (mq.size() < int'(DEPTH)) || pop;
    cap = !m_ack && (dest_req == 1'b1) && can;
    if (pop) begin
      rx.push_back(obs_head);
      void'(mq.pop_front());
    end
    if (cap) mq.push_back(dest_in);
    m_ack = m_ack ? (dest_req == 1'b1) : cap;
  endfunction

  task automatic check_model();
    bit exp_stall;
    exp_stall = !m_ack && (dest_req == 1'b1) &&
                !((mq.size() < int'(DEPTH)) || (mq.size() > 0 && m_ready == 1'b1));
    check_val("ack",   32'(dest_ack),  32'(m_ack));
    check_val("fill",  32'(fill),      32'(mq.size()));
    check_val("valid", 32'(m_valid),   32'(mq.size() != 0));
    check_val("stall", 32'(req_stall), 32'(exp_stall));
    if (mq.size() > 0) check_val("data", 32'(m_data), 32'(mq[0]));
    if (dest_ack === 1'b1 && prev_ack === 1'b0)
      check_val("ack_rise_after_req", 32'(last_req), 32'(1));
    if (dest_ack === 1'b0 && prev_ack === 1'b1 && last_rst === 1'b1)
      check_val("ack_fall_after_noreq", 32'(last_req), 32'(0));
    prev_ack = dest_ack;
    obs_head = m_data;
  endtask

  // Inputs change at negedge; model advances on posedge; outputs checked at negedge.
  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    dest_rst_n = 1'b0;
    dest_req   = 1'b0;
    m_ready    = 1'b0;
    cycle();
    dest_rst_n = 1'b1;
  endtask

  task automatic send_word(input logic [WIDTH-1:0] w);
    dest_req = 1'b1;
    dest_in  = w;
    cycle();
    dest_req = 1'b0;
    cycle();
  endtask

  // Handshake source model state (source and sync stages run off the same clock).
  bit               src_send;
  logic [WIDTH-1:0] src_data;
  logic [SYNC-1:0]  req_pipe;
  logic [SYNC-1:0]  ack_pipe;
  int               phase;
  int               sent_cnt;
  int               budget;

  initial begin
    dest_rst_n = 1'b0;
    dest_req   = 1'b0;
    dest_in    = '0;
    m_ready    = 1'b0;
    @(negedge clk);
    do_reset();
    cycle();
    check_val("rst_ack",   32'(dest_ack),  32'(0));
    check_val("rst_valid", 32'(m_valid),   32'(0));
    check_val("rst_fill",  32'(fill),      32'(0));
    check_val("rst_stall", 32'(req_stall), 32'(0));

    // Single word, then long hold.
    dest_req = 1'b1;
    dest_in  = 16'hA5A5;
    cycle();
    check_val("single_ack",   32'(dest_ack), 32'(1));
    check_val("single_valid", 32'(m_valid),  32'(1));
    check_val("single_data",  32'(m_data),   32'(16'hA5A5));
    check_val("single_fill",  32'(fill),     32'(1));
    repeat (10) cycle();
    check_val("hold_fill", 32'(fill),     32'(1));
    check_val("hold_ack",  32'(dest_ack), 32'(1));
    dest_req = 1'b0;
    cycle();
    check_val("release_ack", 32'(dest_ack), 32'(0));

    // Full FIFO back-pressure.
    do_reset();
    for (int i = 1; i <= 4; i++) send_word(WIDTH'(i));
    dest_req = 1'b1;
    dest_in  = 16'h0005;
    cycle();
    cycle();
    check_val("full_ack",   32'(dest_ack),  32'(0));
    check_val("full_stall", 32'(req_stall), 32'(1));
    check_val("full_fill",  32'(fill),      32'(4));
    m_ready = 1'b1;
    cycle();
    m_ready = 1'b0;
    check_val("full_pp_fill",  32'(fill),      32'(4));
    check_val("full_pp_ack",   32'(dest_ack),  32'(1));
    check_val("full_pp_stall", 32'(req_stall), 32'(0));
    check_val("full_pp_head",  32'(m_data),    32'(16'h0002));
    check_val("full_pp_pop",   32'(rx[rx.size()-1]), 32'(16'h0001));
    dest_req = 1'b0;
    cycle();

    // Reset in the middle of a transfer.
    do_reset();
    send_word(16'h0A0A);
    dest_req = 1'b1;
    dest_in  = 16'h0B0B;
    cycle();
    check_val("mid_pre_fill", 32'(fill),     32'(2));
    check_val("mid_pre_ack",  32'(dest_ack), 32'(1));
    dest_rst_n = 1'b0;
    cycle();
    check_val("mid_ack",   32'(dest_ack), 32'(0));
    check_val("mid_valid", 32'(m_valid),  32'(0));
    check_val("mid_fill",  32'(fill),     32'(0));
    dest_rst_n = 1'b1;
    cycle();
    check_val("mid_recap_fill", 32'(fill),   32'(1));
    check_val("mid_recap_data", 32'(m_data), 32'(16'h0B0B));
    dest_req = 1'b0;
    cycle();

    // Simultaneous push and pop at fill=1.
    do_reset();
    send_word(16'h1111);
    dest_req = 1'b1;
    dest_in  = 16'h2222;
    m_ready  = 1'b1;
    cycle();
    m_ready  = 1'b0;
    dest_req = 1'b0;
    check_val("pp1_fill", 32'(fill),   32'(1));
    check_val("pp1_data", 32'(m_data), 32'(16'h2222));
    cycle();

    // Randomized ordering run through a handshake model with 4-stage syncs.
    do_reset();
    rx.delete();
    sent.delete();
    src_send = 1'b0;
    src_data = '0;
    req_pipe = '0;
    ack_pipe = '0;
    phase    = 0;
    sent_cnt = 0;
    budget   = 0;
    while (budget < 20000) begin
      ack_pipe = {ack_pipe[SYNC-2:0], dest_ack};
      case (phase)
        0: if (sent_cnt < NWORDS) begin
             src_data = WIDTH'($urandom);
             sent.push_back(src_data);
             src_send = 1'b1;
             sent_cnt++;
             phase = 1;
           end
        1: if (ack_pipe[SYNC-1]) begin
             src_send = 1'b0;
             phase = 2;
           end
        default: if (!ack_pipe[SYNC-1]) phase = 0;
      endcase
      req_pipe = {req_pipe[SYNC-2:0], src_send};
      dest_req = req_pipe[SYNC-1];
      dest_in  = src_data;
      m_ready  = (sent_cnt == NWORDS && phase == 0) ? 1'b1 : 1'(($urandom_range(0, 1)));
      cycle();
      budget++;
      if (sent_cnt == NWORDS && phase == 0 && rx.size() == NWORDS) break;
    end
    m_ready  = 1'b0;
    dest_req = 1'b0;
    check_val("rand_budget_ok", 32'(budget < 20000), 32'(1));
    check_val("rand_rx_count",  32'(rx.size()),      32'(NWORDS));
    for (int i = 0; i < NWORDS; i++) begin
      if (i < rx.size()) check_val($sformatf("rand_word_%0d", i), 32'(rx[i]), 32'(sent[i]));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cdc_hsk_dest_ctrl.md
# cdc_hsk_dest_ctrl

Destination-side responder for `xpm_cdc_handshake` instantiated with `DEST_EXT_HSK = 1`. Runs entirely in the destination clock domain. It watches `dest_req`, captures the synchronized word into a small first-word-fall-through FIFO, and drives `dest_ack` through the full four-phase handshake. It presents the captured words downstream on a valid/ready stream. When the FIFO is full it withholds the acknowledge, so back-pressure reaches the source side through the handshake itself.

## Interface
- `WIDTH`, 16: data width; must match the handshake `WIDTH`.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

- `dest_clk`  in  1  destination clock.
- `dest_rst_n`  in  1  reset, synchronous to `dest_clk`, active-low.
- `dest_req`  in  1  request from `xpm_cdc_handshake.dest_req`.
- `dest_in`  in  WIDTH  data from `xpm_cdc_handshake.dest_out`; stable while `dest_req`=1.
- `dest_ack`  out  1  acknowledge to `xpm_cdc_handshake.dest_ack`.
- `m_data`  out  WIDTH  head-of-FIFO word.
- `m_valid`  out  1  `m_data` valid.
- `m_ready`  in  1  downstream accepts `m_data`.
- `fill`  out  $clog2(DEPTH+1)  current FIFO occupancy.
- `req_stall`  out  1  high while a request is pending and cannot be accepted.

## Operation
- FSM states are `IDLE` and `ACK`.
- `IDLE`:
  - `dest_ack`=0.
  - If `dest_req`=1 and `push_ok`: push `dest_in`, go to `ACK`.
  - `push_ok` = (`fill` < DEPTH) or `pop`, where `pop` = `m_valid` & `m_ready`.
  - If `dest_req`=1 and not `push_ok`: stay in `IDLE` with `req_stall`=1.
- `ACK`:
  - `dest_ack`=1 and no push, whatever the level of `dest_req`.
  - When `dest_req`=0: go to `IDLE`.
- Exactly one push per request. A request held high for any number of cycles after capture never produces a second push.
- FIFO:
  - Circular buffer with read/write pointers of $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Occupancy is tracked separately in `fill`.
  - `m_valid` = (`fill` ≠ 0). `m_data` = mem[rd_ptr].
  - Simultaneous push and pop: `fill` unchanged, both pointers advance.
  - Pop while empty cannot occur, because `m_valid` gates it.
- `req_stall` is combinational: (state==`IDLE`) & `dest_req` & !`push_ok`.
- Reset values:
  - State `IDLE`; `dest_ack`=0; `fill`=0; `m_valid`=0; pointers 0.
  - `m_data` is undefined while `m_valid`=0.
- Reset mid-transfer:
  - The FSM returns to `IDLE` and all FIFO contents are discarded.
  - If `dest_req` is still high after reset release, it is treated as a new request and captured again. Both ends of the handshake must therefore be reset together.

## Timing
- Capture latency: with `dest_req` sampled high at edge N, state `IDLE` and `push_ok`:
  - from N+1: `dest_ack`=1 and `fill` incremented.
  - from N+1: `m_valid`=1 (FWFT) if the FIFO was empty.
- Ack release: with `dest_req` sampled low at edge M in `ACK`, `dest_ack`=0 from M+1. A new request can be captured at M+1 at the earliest.
- Minimum local turnaround is 2 cycles per word. Real throughput is bounded by the handshake's `SRC_SYNC_FF`/`DEST_SYNC_FF` round trip.
- `dest_ack` is a registered output (state-decoded flop), so it is glitch-free for the synchronizer.
- `fill`, `m_valid` and `m_data` update only on `dest_clk` edges. Pop takes effect at the edge where `m_valid` & `m_ready`.

## Structure
- Package `cdc_hsk_pkg`:
  - `hsk_state_t` enum {`IDLE`, `ACK`}.
  - Function `fill_width(depth)` returning $clog2(depth+1).
- Sub-module `cdc_hsk_fifo`: synchronous FWFT FIFO with parameters WIDTH and DEPTH.
  - Ports: clk, rst_n, push, push_data, pop, pop_data, fill.
  - Same-cycle push/pop when full is allowed.
- Top level: FSM plus `cdc_hsk_fifo` instance; about 150 lines total.

## Test plan
- Single word:
  - WIDTH=16, `m_ready`=0; `dest_req`=1 with `dest_in`=0xA5A5 → next cycle `dest_ack`=1, `m_valid`=1, `m_data`=0xA5A5, `fill`=1.
  - Drop `dest_req` → `dest_ack`=0 one cycle later.
- Long request hold:
  - `dest_req` held high for 10 cycles after capture → `fill` stays 1 and `dest_ack` stays 1 throughout.
- Full FIFO:
  - DEPTH=4, `m_ready`=0; transfer 0x0001–0x0004, then assert a 5th request 0x0005 → `dest_ack` stays 0, `req_stall`=1, `fill`=4.
  - Pulse `m_ready` for one cycle → 0x0001 popped, 0x0005 pushed in the same cycle, `fill`=4, `dest_ack`=1 next cycle, `req_stall`=0.
- Ordering:
  - Bench model of `xpm_cdc_handshake` (DEST_SYNC_FF=4) sends 64 random words with random `m_ready` → output sequence identical, with no drops or duplicates.
  - Every `dest_ack` rise is preceded by `dest_req`=1, and every fall is preceded by `dest_req`=0.
- Reset mid-transfer:
  - In `ACK` with `fill`=2, assert `dest_rst_n`=0 for one cycle → next cycle `dest_ack`=0, `m_valid`=0, `fill`=0.
  - `dest_req` still high at release → recaptured, `fill`=1.
- Push/pop at fill=1:
  - `fill`=1 with head 0x1111; request 0x2222 arrives with `m_ready`=1 → `fill` stays 1 and `m_data`=0x2222 next cycle.
